// File: rtl/button_bus_pkg.sv
// Shared constants and types for the push-button bus peripheral.
// Register offsets, ID constant, IRQ state and address window helper.
package button_bus_pkg;

  localparam logic [1:0] OFF_LEVEL = 2'd0;
  localparam logic [1:0] OFF_EVENT = 2'd1;
  localparam logic [1:0] OFF_MASK  = 2'd2;
  localparam logic [1:0] OFF_ID    = 2'd3;

  localparam logic [7:0] ID_VALUE = 8'hB5;

  typedef enum logic {
    IRQ_IDLE,
    IRQ_RAISED
  } irq_state_t;

  // Four-register window starting at base, wrap-safe.
  function automatic logic in_window(
    input logic [7:0] addr,
    input logic [7:0] base
  );
    logic [7:0] d;
    d = addr - base;
    return d[7:2] == 6'd0;
  endfunction

  function automatic logic [1:0] reg_off(
    input logic [7:0] addr,
    input logic [7:0] base
  );
    logic [7:0] d;
    d = addr - base;
    return d[1:0];
  endfunction

endpackage

// File: rtl/button_bus_if.sv
// Processor bus control and interrupt lines shared by bus peripherals.
// The tristate data bus is carried as a separate inout port.
interface button_bus_if;

  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE
  );

endinterface

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter, debounced level
// and a rise pulse coincident with the level going high.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          fire;

  assign fire = (s2 != level) && (cnt == LAST);
  assign rise = fire && s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (fire) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_bus_peripheral.sv
// Memory-mapped debounced button input block with latched rise events
// and a maskable raise/ack interrupt.
module button_bus_peripheral
  import button_bus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR       = 8'hE0,
  parameter int         NUM_BTN         = 5,
  parameter int         DEBOUNCE_CYCLES = 100000
) (
  input  logic               CLK,
  input  logic               RESET,
  button_bus_if.slave        bus,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [NUM_BTN-1:0] BTN_IN
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] event_q;
  logic [NUM_BTN-1:0] mask_q;
  logic [NUM_BTN-1:0] new_q;
  logic [NUM_BTN-1:0] clr;

  logic       hit;
  logic       wr_hit;
  logic       rd_hit;
  logic [1:0] off;
  logic       pending;
  logic [7:0] rd_mux;
  logic [7:0] rdata_q;
  logic       oe_q;
  logic       raise_q;
  irq_state_t state;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (CLK),
      .rst  (RESET),
      .btn  (BTN_IN[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  assign hit    = in_window(bus.BUS_ADDR, BASE_ADDR);
  assign off    = reg_off(bus.BUS_ADDR, BASE_ADDR);
  assign wr_hit = hit && bus.BUS_WE;
  assign rd_hit = hit && !bus.BUS_WE;

  assign clr = (wr_hit && off == OFF_EVENT)
             ? BUS_DATA[NUM_BTN-1:0] : '0;

  // Only edges latched on the previous cycle can raise the request.
  assign pending = |(new_q & mask_q);

  always_comb begin
    rd_mux = '0;
    unique case (off)
      OFF_LEVEL: rd_mux[NUM_BTN-1:0] = level;
      OFF_EVENT: rd_mux[NUM_BTN-1:0] = event_q;
      OFF_MASK:  rd_mux[NUM_BTN-1:0] = mask_q;
      OFF_ID:    rd_mux = ID_VALUE;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      event_q <= '0;
      mask_q  <= '0;
      new_q   <= '0;
      oe_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      event_q <= (event_q & ~clr) | rise;
      if (wr_hit && off == OFF_MASK) begin
        mask_q <= BUS_DATA[NUM_BTN-1:0];
      end
      new_q   <= rise;
      oe_q    <= rd_hit;
      rdata_q <= rd_hit ? rd_mux : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IRQ_IDLE;
      raise_q <= 1'b0;
    end else begin
      unique case (state)
        IRQ_IDLE: begin
          if (pending) begin
            state   <= IRQ_RAISED;
            raise_q <= 1'b1;
          end
        end
        IRQ_RAISED: begin
          if (bus.BUS_INTERRUPT_ACK && !pending) begin
            state   <= IRQ_IDLE;
            raise_q <= 1'b0;
          end
        end
        default: begin
          state   <= IRQ_IDLE;
          raise_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUS_INTERRUPT_RAISE = raise_q;
  assign BUS_DATA = oe_q ? rdata_q : 8'bz;

endmodule

// File: tb/tb_button_bus_peripheral.sv
// Bench for button_bus_peripheral: directed scenarios plus random
// traffic checked against a per-edge behavioural model.
module tb_button_bus_peripheral;

  localparam int         DEB    = 4;
  localparam int         NB     = 5;
  localparam logic [7:0] BASE   = 8'hE0;
  localparam logic [7:0] IDLE_A = 8'h00;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn = '0;
  logic          tb_oe = 1'b0;
  logic [7:0]    tb_wdata = 8'h00;
  wire  [7:0]    bus_data;

  int total = 0;
  int bad = 0;

  button_bus_if bif();

  assign bus_data = tb_oe ? tb_wdata : 8'bz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (bus_data[i]);
  end

  button_bus_peripheral #(
    .BASE_ADDR      (BASE),
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .bus     (bif),
    .BUS_DATA(bus_data),
    .BTN_IN  (btn)
  );

  always #5 clk = ~clk;

  logic [NB-1:0] m_pipe[$];
  logic [NB-1:0] m_lvl, m_ev, m_mask, m_new;
  int            m_run[NB];
  logic          m_raised;
  logic          m_oe;
  logic [7:0]    m_rd;

  task automatic model_edge();
    logic [7:0]    bd, off8, rd;
    logic [NB-1:0] sync, rise, clr;
    logic          inr, we, hitm;
    bd = tb_oe ? tb_wdata : (m_oe ? m_rd : 8'hFF);
    if (rst) begin
      m_lvl = '0; m_ev = '0; m_mask = '0; m_new = '0;
      m_raised = 1'b0; m_oe = 1'b0; m_rd = '0;
      m_pipe = {};
      m_pipe.push_back('0);
      m_pipe.push_back('0);
      for (int i = 0; i < NB; i++) m_run[i] = 0;
    end else begin
      sync = m_pipe.pop_front();
      m_pipe.push_back(btn);
      we   = bif.BUS_WE;
      off8 = bif.BUS_ADDR - BASE;
      inr  = off8 < 8'd4;
      case (off8[1:0])
        2'd0:    rd = 8'(m_lvl);
        2'd1:    rd = 8'(m_ev);
        2'd2:    rd = 8'(m_mask);
        default: rd = 8'hB5;
      endcase
      hitm = |(m_new & m_mask);
      if (!m_raised) m_raised = hitm;
      else if (bif.BUS_INTERRUPT_ACK && !hitm) m_raised = 1'b0;
      clr = (inr && we && off8 == 8'd1) ? bd[NB-1:0] : '0;
      if (inr && we && off8 == 8'd2) m_mask = bd[NB-1:0];
      rise = '0;
      for (int i = 0; i < NB; i++) begin
        if (sync[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = sync[i];
            m_run[i] = 0;
            rise[i]  = sync[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_ev  = (m_ev & ~clr) | rise;
      m_new = rise;
      m_oe  = inr && !we;
      m_rd  = m_oe ? rd : 8'h00;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    bif.BUS_ADDR = a;
    bif.BUS_WE = 1'b0;
    step();
    v = bus_data;
    bif.BUS_ADDR = IDLE_A;
    step();
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    bif.BUS_ADDR = BASE + 8'(off);
    bif.BUS_WE = 1'b1;
    tb_oe = 1'b1;
    tb_wdata = d;
    step();
    tb_oe = 1'b0;
    bif.BUS_WE = 1'b0;
    bif.BUS_ADDR = IDLE_A;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      bad++;
      $display("FAIL reset_raise: got %b want 0", bif.BUS_INTERRUPT_RAISE);
    end
    total++;
    if (bus_data !== 8'hFF) begin
      bad++;
      $display("FAIL reset_bus_z: got %h want FF(pulled)", bus_data);
    end
    rd(BASE + 8'd3, v);
    total++;
    if (v !== 8'hB5) begin
      bad++;
      $display("FAIL id_read: got %h want B5", v);
    end
    total++;
    if (bus_data !== 8'hFF) begin
      bad++;
      $display("FAIL read_release: got %h want FF(pulled)", bus_data);
    end
    rd(BASE + 8'd2, v);
    total++;
    if (v !== 8'h00) begin
      bad++;
      $display("FAIL mask_reset: got %h want 00", v);
    end
    rd(BASE + 8'd1, v);
    total++;
    if (v !== 8'h00) begin
      bad++;
      $display("FAIL event_reset: got %h want 00", v);
    end
    bif.BUS_ADDR = BASE + 8'd4;
    for (int j = 0; j < 2; j++) begin
      step();
      total++;
      if (bus_data !== 8'hFF) begin
        bad++;
        $display("FAIL out_of_range_z: got %h want FF(pulled)", bus_data);
      end
    end
    bif.BUS_ADDR = IDLE_A;
  endtask

  task automatic test_glitch();
    logic [7:0] v;
    btn[0] = 1'b1;
    idle(3);
    btn[0] = 1'b0;
    idle(8);
    rd(BASE, v);
    total++;
    if (v !== 8'h00) begin
      bad++;
      $display("FAIL glitch_level: got %h want 00", v);
    end
    rd(BASE + 8'd1, v);
    total++;
    if (v !== 8'h00) begin
      bad++;
      $display("FAIL glitch_event: got %h want 00", v);
    end
  endtask

  task automatic test_level();
    logic [7:0] v, e;
    btn[0] = 1'b1;
    bif.BUS_ADDR = BASE;
    bif.BUS_WE = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      e = (j >= 7) ? 8'h01 : 8'h00;
      total++;
      if (bus_data !== e) begin
        bad++;
        $display("FAIL level_timing[%0d]: got %h want %h", j, bus_data, e);
      end
    end
    bif.BUS_ADDR = IDLE_A;
    step();
    rd(BASE + 8'd1, v);
    total++;
    if (v !== 8'h01) begin
      bad++;
      $display("FAIL level_event: got %h want 01", v);
    end
    btn[0] = 1'b0;
    idle(8);
    wr(2'd1, 8'h01);
    rd(BASE + 8'd1, v);
    total++;
    if (v !== 8'h00) begin
      bad++;
      $display("FAIL w1c_clear: got %h want 00", v);
    end
  endtask

  task automatic test_irq();
    logic [7:0] v;
    logic       e;
    wr(2'd2, 8'h04);
    btn = 5'h04;
    for (int j = 1; j <= 10; j++) begin
      step();
      e = (j >= 7);
      total++;
      if (bif.BUS_INTERRUPT_RAISE !== e) begin
        bad++;
        $display("FAIL irq_raise[%0d]: got %b want %b", j,
                 bif.BUS_INTERRUPT_RAISE, e);
      end
    end
    bif.BUS_INTERRUPT_ACK = 1'b1;
    step();
    bif.BUS_INTERRUPT_ACK = 1'b0;
    total++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      bad++;
      $display("FAIL irq_ack: got %b want 0", bif.BUS_INTERRUPT_RAISE);
    end
    btn = 5'h06;
    for (int j = 1; j <= 10; j++) begin
      step();
      total++;
      if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
        bad++;
        $display("FAIL irq_unmasked[%0d]: got %b want 0", j,
                 bif.BUS_INTERRUPT_RAISE);
      end
    end
    rd(BASE + 8'd1, v);
    total++;
    if (v !== 8'h06) begin
      bad++;
      $display("FAIL irq_events: got %h want 06", v);
    end
    btn = '0;
    idle(8);
  endtask

  task automatic test_set_wins();
    logic [7:0] v;
    btn = 5'h02;
    idle(5);
    wr(2'd1, 8'h02);
    rd(BASE + 8'd1, v);
    total++;
    if (v !== 8'h06) begin
      bad++;
      $display("FAIL set_beats_clear: got %h want 06", v);
    end
    wr(2'd1, 8'h06);
    rd(BASE + 8'd1, v);
    total++;
    if (v !== 8'h00) begin
      bad++;
      $display("FAIL clear_both: got %h want 00", v);
    end
    btn = '0;
    idle(8);
  endtask

  task automatic test_ack_collision();
    wr(2'd2, 8'h1F);
    btn = 5'h08;
    idle(7);
    total++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b1) begin
      bad++;
      $display("FAIL coll_pre: got %b want 1", bif.BUS_INTERRUPT_RAISE);
    end
    btn = 5'h18;
    idle(6);
    bif.BUS_INTERRUPT_ACK = 1'b1;
    step();
    bif.BUS_INTERRUPT_ACK = 1'b0;
    total++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b1) begin
      bad++;
      $display("FAIL coll_ack_edge: got %b want 1", bif.BUS_INTERRUPT_RAISE);
    end
    step();
    bif.BUS_INTERRUPT_ACK = 1'b1;
    step();
    bif.BUS_INTERRUPT_ACK = 1'b0;
    total++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      bad++;
      $display("FAIL coll_lone_ack: got %b want 0", bif.BUS_INTERRUPT_RAISE);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    btn = 5'h19;
    idle(7);
    total++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre: got %b want 1", bif.BUS_INTERRUPT_RAISE);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
      bad++;
      $display("FAIL rmid_raise: got %b want 0", bif.BUS_INTERRUPT_RAISE);
    end
    for (int k = 0; k < 3; k++) begin
      rd(BASE + 8'(2 - k), v);
      total++;
      if (v !== 8'h00) begin
        bad++;
        $display("FAIL rmid_reg%0d: got %h want 00", 2 - k, v);
      end
      total++;
      if (bif.BUS_INTERRUPT_RAISE !== 1'b0) begin
        bad++;
        $display("FAIL rmid_quiet%0d: got %b want 0", k,
                 bif.BUS_INTERRUPT_RAISE);
      end
    end
    btn = '0;
    idle(10);
  endtask

  task automatic test_random();
    logic [7:0] eb;
    int         op;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      bif.BUS_INTERRUPT_ACK = ($urandom_range(0, 7) == 0);
      bif.BUS_ADDR = IDLE_A;
      bif.BUS_WE = 1'b0;
      tb_oe = 1'b0;
      op = $urandom_range(0, 3);
      if (op == 1) begin
        if ($urandom_range(0, 3) == 0) bif.BUS_ADDR = 8'($urandom);
        else bif.BUS_ADDR = BASE + 8'($urandom_range(0, 5));
      end else if (op == 2 && !m_oe) begin
        bif.BUS_ADDR = BASE + 8'($urandom_range(0, 3));
        bif.BUS_WE = 1'b1;
        tb_oe = 1'b1;
        tb_wdata = 8'($urandom);
      end
      step();
      eb = m_oe ? m_rd : (tb_oe ? tb_wdata : 8'hFF);
      total++;
      if (bif.BUS_INTERRUPT_RAISE !== m_raised) begin
        bad++;
        $display("FAIL rand_raise[%0d]: got %b want %b", n,
                 bif.BUS_INTERRUPT_RAISE, m_raised);
      end
      total++;
      if (bus_data !== eb) begin
        bad++;
        $display("FAIL rand_bus[%0d]: got %h want %h", n, bus_data, eb);
      end
    end
    rst = 1'b0;
    tb_oe = 1'b0;
    bif.BUS_WE = 1'b0;
    bif.BUS_ADDR = IDLE_A;
    bif.BUS_INTERRUPT_ACK = 1'b0;
    step();
  endtask

  initial begin
    bif.BUS_ADDR = IDLE_A;
    bif.BUS_WE = 1'b0;
    bif.BUS_INTERRUPT_ACK = 1'b0;
    m_pipe = {};
    m_pipe.push_back('0);
    m_pipe.push_back('0);
    m_oe = 1'b0;
    m_rd = '0;
    test_reset();
    test_glitch();
    test_level();
    test_irq();
    test_set_wins();
    test_ack_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_bus_peripheral.md
Name: button_bus_peripheral

Overview:
- Memory-mapped input peripheral on the 8-bit processor bus. Feeds the Processor's bus and interrupt inputs alongside Timer and MouseBusWrapper.
- Synchronises and debounces up to five push-buttons, latches rising-edge events, and raises a maskable interrupt with a raise/ack handshake.
- Connects to one spare bit of the BUS_INTERRUPTS_RAISE/ACK vector.

Parameters:
- BASE_ADDR, 8'hE0, base bus address; the block decodes BASE_ADDR+0 to BASE_ADDR+3.
- NUM_BTN, 5, number of button inputs (1..8).
- DEBOUNCE_CYCLES, 100000, number of stable CLK cycles before a level is accepted.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- BUS_ADDR  input  8  processor bus address.
- BUS_DATA  inout  8  shared data bus; high-Z unless this block is driving a read.
- BUS_WE  input  1  bus write enable (1 = write, 0 = read).
- BUS_INTERRUPT_RAISE  output  1  interrupt request level.
- BUS_INTERRUPT_ACK  input  1  one-cycle acknowledge pulse from the Processor.
- BTN_IN  input  NUM_BTN  raw asynchronous button pins.

Behaviour:
- Reset (CLK is the only clock; reset is synchronous, active-high): all registers go to 0; BUS_INTERRUPT_RAISE=0; BUS_DATA=Z.
  - If reset asserts mid-debounce or mid-interrupt, all state is cleared. No event or interrupt is generated on the following cycle even if a button is held.
- Synchroniser: two flops per bit. The synchronised value lags BTN_IN by 2 cycles.
- Debounce, per bit:
  - Counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If sync != level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still != level, level <= sync and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change level.
- Edge detect: a 0->1 transition of level sets EVENT[i] in the same cycle level updates.
- Register map:
  - +0 LEVEL: read-only, debounced levels, zero-extended.
  - +1 EVENT: read returns the flags; a write clears every bit written as 1 (write-1-to-clear).
  - +2 MASK: read/write, reset 0.
  - +3 ID: read-only constant 8'hB5.
- Writes take effect on the clock edge where BUS_ADDR is in range and BUS_WE=1. Writes to LEVEL and ID are ignored.
- Read handshake:
  - If BUS_ADDR is in range and BUS_WE=0 at edge N, the block registers the data and an output enable.
  - BUS_DATA is driven for the cycle following edge N (1-cycle latency) and released at edge N+1 unless the read condition still holds.
  - Any out-of-range address, or BUS_WE=1, gives high-Z.
- Upper bits of any register above NUM_BTN read 0.
- Simultaneous events:
  - A new edge and a W1C clear on the same EVENT bit in the same cycle: the set wins.
  - A MASK write is used from the next cycle.
- Interrupt FSM:
  - IDLE -> RAISED when a newly set EVENT bit is also set in MASK (pending = new_events & MASK != 0). BUS_INTERRUPT_RAISE=1 from the following cycle.
  - RAISED -> IDLE on BUS_INTERRUPT_ACK=1, unless a new masked edge arrives in that same cycle, in which case the FSM stays RAISED.
  - In RAISED, further events do not re-pulse; the request stays high.
  - Already-latched EVENT bits do not re-raise after ACK. Software must read EVENT and clear it.
  - Setting MASK while EVENT bits are already latched does not raise an interrupt; only new edges do.
  - ACK received in IDLE is ignored.

Decomposition:
- Shared package (button_bus_pkg):
  - register offset constants: OFF_LEVEL=0, OFF_EVENT=1, OFF_MASK=2, OFF_ID=3;
  - ID_VALUE=8'hB5;
  - irq_state_t enum {IRQ_IDLE, IRQ_RAISED}.
- Sub-module btn_debounce:
  - per-bit synchroniser, counter, level and rise pulse;
  - parameterised by DEBOUNCE_CYCLES;
  - instantiated NUM_BTN times via generate.
- Top level holds the bus decode, registers, tristate and IRQ FSM.

Test Plan (DEBOUNCE_CYCLES=4, BASE_ADDR=8'hE0):
- Reset, then read 0xE3 -> BUS_DATA=8'hB5 one cycle after the address. Read 0xE2 -> 8'h00. Address 0xE4 -> BUS_DATA stays Z. RAISE=0.
- Toggle BTN_IN[0] with a 3-cycle high glitch -> LEVEL reads 8'h00 and EVENT reads 8'h00. Hold it high for 10 cycles -> LEVEL=8'h01 and EVENT=8'h01, level updating 2+4 cycles after the input rises.
- Write MASK=8'h04, then press BTN_IN[2] -> RAISE rises one cycle after EVENT[2] sets and stays high. Pulse ACK -> RAISE=0 the next cycle. Press BTN_IN[1] (unmasked) -> RAISE stays 0 and EVENT reads 8'h06.
- Write 8'h02 to 0xE1 in the same cycle BTN_IN[1] produces a new edge -> EVENT[1] remains 1. A later write of 8'h06 -> EVENT=8'h00.
- With MASK=8'h1F, a second masked edge coincides with ACK -> RAISE remains 1. A subsequent lone ACK -> RAISE=0.
- Assert RESET while RAISE=1 and a button is held -> all registers are 0 and RAISE=0 the next cycle, with no spurious event for DEBOUNCE_CYCLES+2 cycles after reset.
